// File: rtl/irq_ctx_stack.sv
// Interrupt context store: threshold CSR plus a LIFO of {return pc, previous threshold}.
// Latency: CSR read data and top-of-stack are combinational; writes, push and pop land at the next posedge.
// Backpressure: none; push when full and pop when empty are dropped (optional sticky err via CTX_STACK_ERR_EN).
module irq_ctx_stack #(
  parameter int                   StackDepth  = 8,
  parameter int                   PrioWidth   = $clog2(StackDepth),
  parameter int                   PcWidth     = 16,
  parameter logic [11:0]          ThreshAddr  = 12'h347,
  parameter logic [11:0]          DepthAddr   = 12'h350,
  parameter logic [PrioWidth-1:0] ThreshReset = '0
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_csr_enable,
  input  logic [11:0]                         i_csr_addr,
  input  logic [4:0]                          i_rs1_zimm,
  input  logic [31:0]                         i_rs1_data,
  input  logic [2:0]                          i_csr_op,
  input  logic                                i_ext_write_enable,
  input  logic [PrioWidth-1:0]                i_ext_data,
  input  logic                                i_push,
  input  logic                                i_pop,
  input  logic [PcWidth-1:0]                  i_pc_in,
  output logic [31:0]                         o_out,
  output logic [PrioWidth-1:0]                o_thresh,
  output logic [PcWidth+PrioWidth-1:0]        o_data_out,
  output logic [$clog2(StackDepth+1)-1:0]     o_index_out
`ifdef CTX_STACK_ERR_EN
  ,
  output logic                                o_err
`endif
);

  localparam int IdxW  = $clog2(StackDepth + 1);
  localparam int AddrW = $clog2(StackDepth);
  localparam int EntW  = PcWidth + PrioWidth;

  logic [PrioWidth-1:0] r_thresh;
  logic [IdxW-1:0]      r_index;
  logic [EntW-1:0]      r_mem [StackDepth];

  logic [31:0]      w_src;
  logic [31:0]      w_old;
  logic [31:0]      w_new;
  logic             w_sw_we;
  logic             w_empty;
  logic             w_full;
  logic             w_replace;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_wr_en;
  logic [IdxW-1:0]  w_idx_m1;
  logic [AddrW-1:0] w_top;
  logic [AddrW-1:0] w_wr_idx;
  logic [EntW-1:0]  w_entry;
  logic [31:0]      w_out;

  // Immediate forms take the zero-extended 5-bit field, register forms take rs1 data.
  assign w_src = i_csr_op[2] ? {27'd0, i_rs1_zimm} : i_rs1_data;
  assign w_old = {{(32 - PrioWidth){1'b0}}, r_thresh};

  // Decode the software threshold update; set/clear with x0/zero immediate must not write.
  always_comb begin
    w_sw_we = 1'b0;
    w_new   = w_old;
    case (i_csr_op[1:0])
      2'b01: begin
        w_sw_we = 1'b1;
        w_new   = w_src;
      end
      2'b10: begin
        w_sw_we = (i_rs1_zimm != 5'd0);
        w_new   = w_old | w_src;
      end
      2'b11: begin
        w_sw_we = (i_rs1_zimm != 5'd0);
        w_new   = w_old & ~w_src;
      end
      default: begin
        w_sw_we = 1'b0;
        w_new   = w_old;
      end
    endcase
    if (!(i_csr_enable && (i_csr_addr == ThreshAddr))) begin
      w_sw_we = 1'b0;
    end
  end

  // Threshold register; the hardware write path overrides a same-cycle software write.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_thresh <= ThreshReset;
    end else if (i_ext_write_enable) begin
      r_thresh <= i_ext_data;
    end else if (w_sw_we) begin
      r_thresh <= w_new[PrioWidth-1:0];
    end
  end

  assign w_empty     = (r_index == '0);
  assign w_full      = (r_index == IdxW'(StackDepth));
  assign w_idx_m1    = r_index - IdxW'(1);
  assign w_top       = w_idx_m1[AddrW-1:0];
  // push+pop on a non-empty stack swaps the top entry in place.
  assign w_replace   = i_push && i_pop && !w_empty;
  assign w_push_only = i_push && !w_replace && !w_full;
  assign w_pop_only  = i_pop && !i_push && !w_empty;
  assign w_wr_en     = w_replace || w_push_only;
  assign w_wr_idx    = w_replace ? w_top : r_index[AddrW-1:0];
  // The saved priority is the threshold before any same-cycle write.
  assign w_entry     = {i_pc_in, r_thresh};

  // Stack storage and depth counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_index <= '0;
      for (int i = 0; i < StackDepth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[w_wr_idx] <= w_entry;
      end
      if (w_push_only) begin
        r_index <= r_index + IdxW'(1);
      end else if (w_pop_only) begin
        r_index <= w_idx_m1;
      end
    end
  end

`ifdef CTX_STACK_ERR_EN
  logic r_err;

  // Sticky flag for pushes into a full stack or pops from an empty one.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_err <= 1'b0;
    end else if ((i_push && !i_pop && w_full) || (i_pop && !i_push && w_empty)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

  // CSR read mux, returning pre-write values independent of csr_enable.
  always_comb begin
    w_out = '0;
    if (i_csr_addr == ThreshAddr) begin
      w_out[PrioWidth-1:0] = r_thresh;
    end else if (i_csr_addr == DepthAddr) begin
      w_out[IdxW-1:0] = r_index;
`ifdef CTX_STACK_ERR_EN
      w_out[31] = r_err;
`endif
    end
  end

  assign o_out       = w_out;
  assign o_thresh    = r_thresh;
  assign o_index_out = r_index;
  assign o_data_out  = w_empty ? '0 : r_mem[w_top];

endmodule

// File: tb/tb_irq_ctx_stack.sv
// Bench for irq_ctx_stack: directed CSR/stack scenarios then random traffic against a queue-based model.
// Inputs change after the falling edge; registered state is checked on the next falling edge.
// No flow control on the DUT, so every step completes in exactly one clock.
module tb_irq_ctx_stack;

  logic        clk;
  logic        rst_n;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [4:0]  zimm;
  logic [31:0] rs1_data;
  logic [2:0]  csr_op;
  logic        ext_we;
  logic [2:0]  ext_d;
  logic        push;
  logic        pop;
  logic [15:0] pc_in;
  logic [31:0] out;
  logic [2:0]  thresh;
  logic [18:0] data_out;
  logic [3:0]  index_out;
`ifdef CTX_STACK_ERR_EN
  logic        err;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: threshold as an int, stack as queues of saved pc and priority.
  int          m_thresh;
  logic [15:0] q_pc[$];
  int          q_pr[$];
  bit          m_err;

  irq_ctx_stack dut (
    .i_clk              (clk),
    .i_reset            (rst_n),
    .i_csr_enable       (csr_en),
    .i_csr_addr         (csr_addr),
    .i_rs1_zimm         (zimm),
    .i_rs1_data         (rs1_data),
    .i_csr_op           (csr_op),
    .i_ext_write_enable (ext_we),
    .i_ext_data         (ext_d),
    .i_push             (push),
    .i_pop              (pop),
    .i_pc_in            (pc_in),
    .o_out              (out),
    .o_thresh           (thresh),
    .o_data_out         (data_out),
    .o_index_out        (index_out)
`ifdef CTX_STACK_ERR_EN
    ,
    .o_err              (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_out(input logic [11:0] a);
    logic [31:0] v;
    v = '0;
    if (a == 12'h347) v = 32'(m_thresh);
    else if (a == 12'h350) begin
      v = 32'(q_pc.size());
`ifdef CTX_STACK_ERR_EN
      v[31] = m_err;
`endif
    end
    return v;
  endfunction

  function automatic logic [18:0] model_top();
    if (q_pc.size() == 0) return '0;
    return {q_pc[q_pc.size()-1], 3'(q_pr[q_pr.size()-1])};
  endfunction

  task automatic model_reset();
    m_thresh = 0;
    q_pc.delete();
    q_pr.delete();
    m_err = 0;
  endtask

  // Apply one clock edge worth of behaviour to the model.
  task automatic model_edge();
    int          old_t;
    int          nt;
    logic [31:0] src;
    old_t = m_thresh;
    nt    = m_thresh;
    src   = csr_op[2] ? 32'(zimm) : rs1_data;
    if (csr_en && csr_addr == 12'h347) begin
      if (csr_op == 3'b001 || csr_op == 3'b101) nt = int'(src % 8);
      else if ((csr_op == 3'b010 || csr_op == 3'b110) && zimm != 0) nt = int'((32'(old_t) | src) % 8);
      else if ((csr_op == 3'b011 || csr_op == 3'b111) && zimm != 0) nt = int'((32'(old_t) & ~src) % 8);
    end
    if (ext_we) nt = int'(ext_d);
    if (push && pop && q_pc.size() > 0) begin
      q_pc[q_pc.size()-1] = pc_in;
      q_pr[q_pr.size()-1] = old_t;
    end else if (push) begin
      if (q_pc.size() < 8) begin
        q_pc.push_back(pc_in);
        q_pr.push_back(old_t);
      end else m_err = 1;
    end else if (pop) begin
      if (q_pc.size() > 0) begin
        void'(q_pc.pop_back());
        void'(q_pr.pop_back());
      end else m_err = 1;
    end
    m_thresh = nt;
  endtask

  task automatic idle_inputs();
    csr_en = 0; csr_addr = 12'h000; zimm = 0; rs1_data = 0; csr_op = 0;
    ext_we = 0; ext_d = 0; push = 0; pop = 0; pc_in = 0;
  endtask

  // Drive one cycle of stimulus, check the combinational read, then the registered state.
  task automatic step(input logic en, input logic [11:0] a, input logic [4:0] z, input logic [31:0] d,
                      input logic [2:0] op, input logic ew, input logic [2:0] ed,
                      input logic pu, input logic po, input logic [15:0] pc);
    csr_en = en; csr_addr = a; zimm = z; rs1_data = d; csr_op = op;
    ext_we = ew; ext_d = ed; push = pu; pop = po; pc_in = pc;
    #1;
    chk("csr_out", 64'(out), 64'(model_out(a)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("thresh", 64'(thresh), 64'(m_thresh));
    chk("index", 64'(index_out), 64'(q_pc.size()));
    chk("data_out", 64'(data_out), 64'(model_top()));
`ifdef CTX_STACK_ERR_EN
    chk("err", 64'(err), 64'(m_err));
`endif
  endtask

  task automatic do_push(input logic [15:0] pc);
    step(0, 12'h000, 0, 0, 0, 0, 0, 1, 0, pc);
  endtask

  task automatic do_pop();
    step(0, 12'h000, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    logic [18:0] top_before;
    model_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    chk("rst_thresh", 64'(thresh), 64'd0);
    chk("rst_index", 64'(index_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    csr_addr = 12'h347; #1;
    chk("rst_rd_347", 64'(out), 64'd0);
    csr_addr = 12'h350; #1;
    chk("rst_rd_350", 64'(out), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // CSR ops on the threshold
    step(1, 12'h347, 5, 0, 3'b101, 0, 0, 0, 0, 0);
    chk("rwi5", 64'(thresh), 64'd5);
    step(1, 12'h347, 1, 0, 3'b111, 0, 0, 0, 0, 0);
    chk("rci1", 64'(thresh), 64'd4);
    step(1, 12'h347, 0, 3, 3'b010, 0, 0, 0, 0, 0);
    chk("rs_x0", 64'(thresh), 64'd4);
    step(1, 12'h347, 7, 32'h1F, 3'b100, 0, 0, 0, 0, 0);
    chk("op100", 64'(thresh), 64'd4);
    step(1, 12'h350, 3, 0, 3'b101, 0, 0, 0, 0, 0);
    chk("depth_ro", 64'(index_out), 64'd0);
    step(1, 12'h347, 0, 0, 3'b101, 0, 0, 0, 0, 0);

    // Ordering: saved prio is the pre-write threshold
    step(1, 12'h347, 2, 0, 3'b101, 0, 0, 1, 0, 16'h0010);
    step(1, 12'h347, 5, 0, 3'b101, 0, 0, 1, 0, 16'h0020);
    chk("ord_idx", 64'(index_out), 64'd2);
    chk("ord_top", 64'(data_out), 64'({16'h0020, 3'd2}));
    do_pop();
    chk("ord_pop", 64'(data_out), 64'({16'h0010, 3'd0}));
    do_pop();
    chk("ord_empty", 64'(data_out), 64'd0);
    do_pop();
    chk("pop_empty", 64'(index_out), 64'd0);

    // Overflow
    for (int i = 0; i < 8; i++) do_push(16'(16'h0100 + i));
    top_before = data_out;
    do_push(16'hBEEF);
    chk("ovf_idx", 64'(index_out), 64'd8);
    chk("ovf_top", 64'(data_out), 64'(top_before));
    for (int i = 0; i < 5; i++) do_pop();

    // Simultaneous push+pop at depth 3, ext write beating software write
    step(0, 12'h000, 0, 0, 0, 0, 0, 1, 1, 16'hCAFE);
    chk("pp_idx", 64'(index_out), 64'd3);
    chk("pp_top", 64'(data_out[18:3]), 64'(16'hCAFE));
    step(1, 12'h347, 1, 0, 3'b101, 1, 7, 0, 0, 0);
    chk("ext_wins", 64'(thresh), 64'd7);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [11:0] a;
      int sel;
      sel = $urandom_range(0, 3);
      a = (sel == 0) ? 12'h347 : (sel == 1) ? 12'h350 : (sel == 2) ? 12'h347 : 12'($urandom);
      step($urandom_range(0, 1), a, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom,
           3'($urandom), $urandom_range(0, 7) == 0, 3'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, 16'($urandom));
    end

    // Async reset mid-cycle at depth 4
    idle_inputs();
    while (q_pc.size() > 4) do_pop();
    while (q_pc.size() < 4) do_push(16'($urandom));
    chk("pre_arst_idx", 64'(index_out), 64'd4);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst_idx", 64'(index_out), 64'd0);
    chk("arst_data", 64'(data_out), 64'd0);
    chk("arst_thresh", 64'(thresh), 64'd0);
    @(negedge clk);
    rst_n = 1;
    do_push(16'h0042);
    chk("post_arst", 64'(data_out), 64'({16'h0042, 3'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
